// File: rtl/candy_regs.sv
// Two-read, one-write register file with a hard-wired zero register and
// same-cycle write-through bypass on both read ports.
module candy_regs #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NREGS];

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (rst && re1 && (raddr1 != '0)) begin
            if (we && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst && re2 && (raddr2 != '0)) begin
            if (we && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
        end
    end

endmodule

// File: tb/tb_candy_regs.sv
// Self-checking bench for candy_regs: directed vector table, hand-written
// async-reset sequence, then random traffic against an array-based model.
module tb_candy_regs;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 16;

    logic              clk;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              re1;
        logic [ADDR_W-1:0] raddr1;
        logic              re2;
        logic [ADDR_W-1:0] raddr2;
        logic [DATA_W-1:0] exp1;
        logic [DATA_W-1:0] exp2;
    } vec_t;

    vec_t vecs[12];

    logic [DATA_W-1:0] mdl [NREGS];

    candy_regs #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NREGS (NREGS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re1   (re1),
        .raddr1(raddr1),
        .rdata1(rdata1),
        .re2   (re2),
        .raddr2(raddr2),
        .rdata2(rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        we     = v.we;
        waddr  = v.waddr;
        wdata  = v.wdata;
        re1    = v.re1;
        raddr1 = v.raddr1;
        re2    = v.re2;
        raddr2 = v.raddr2;
    endtask

    // Reference read: the priority rules applied to the model array.
    function automatic logic [DATA_W-1:0] model_read(input logic r, input logic re,
                                                     input logic [ADDR_W-1:0] ra);
        if (!r || !re || ra == 0) return '0;
        if (we && waddr == ra) return wdata;
        return mdl[ra];
    endfunction

    initial begin
        vecs[0]  = '{1'b1, 4'd1, 24'h124B36, 1'b0, 4'd1, 1'b0, 4'd1, 24'h0,      24'h0};
        vecs[1]  = '{1'b1, 4'd2, 24'h655356, 1'b1, 4'd1, 1'b1, 4'd2, 24'h124B36, 24'h655356};
        vecs[2]  = '{1'b1, 4'd3, 24'h5A0024, 1'b1, 4'd2, 1'b1, 4'd0, 24'h655356, 24'h0};
        vecs[3]  = '{1'b1, 4'd4, 24'h5A0034, 1'b1, 4'd4, 1'b1, 4'd3, 24'h5A0034, 24'h5A0024};
        vecs[4]  = '{1'b0, 4'hx, 24'hx,      1'b1, 4'd3, 1'b1, 4'd4, 24'h5A0024, 24'h5A0034};
        vecs[5]  = '{1'b0, 4'd1, 24'h0,      1'b1, 4'd1, 1'b1, 4'd2, 24'h124B36, 24'h655356};
        vecs[6]  = '{1'b0, 4'd0, 24'h0,      1'b0, 4'd3, 1'b0, 4'd4, 24'h0,      24'h0};
        vecs[7]  = '{1'b1, 4'd0, 24'hFFFFFF, 1'b1, 4'd0, 1'b1, 4'd1, 24'h0,      24'h124B36};
        vecs[8]  = '{1'b0, 4'd0, 24'h0,      1'b1, 4'd0, 1'b1, 4'd0, 24'h0,      24'h0};
        vecs[9]  = '{1'b1, 4'd5, 24'hABCDEF, 1'b1, 4'd5, 1'b1, 4'd5, 24'hABCDEF, 24'hABCDEF};
        vecs[10] = '{1'b0, 4'd0, 24'h0,      1'b1, 4'd2, 1'b1, 4'd5, 24'h655356, 24'hABCDEF};
        vecs[11] = '{1'b0, 4'd0, 24'h0,      1'b1, 4'd2, 1'b1, 4'd2, 24'h655356, 24'h655356};

        rst = 1'b0;
        we = 1'b1; waddr = 4'd7; wdata = 24'h777777;
        re1 = 1'b1; raddr1 = 4'd7; re2 = 1'b1; raddr2 = 4'd1;
        #1;
        checkOutput("reset_rd1", rdata1, '0);
        checkOutput("reset_rd2", rdata2, '0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_rd1", i), rdata1, vecs[i].exp1);
            checkOutput($sformatf("vec%0d_rd2", i), rdata2, vecs[i].exp2);
            @(negedge clk);
        end

        // Reset dropped mid-cycle during a write: outputs clear with no edge.
        we = 1'b1; waddr = 4'd6; wdata = 24'h123456;
        re1 = 1'b1; raddr1 = 4'd1; re2 = 1'b1; raddr2 = 4'd6;
        #1;
        checkOutput("pre_arst_rd1", rdata1, 24'h124B36);
        checkOutput("pre_arst_rd2", rdata2, 24'h123456);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("arst_rd1", rdata1, '0);
        checkOutput("arst_rd2", rdata2, '0);
        @(posedge clk);
        #1;
        checkOutput("arst_edge_rd1", rdata1, '0);
        checkOutput("arst_edge_rd2", rdata2, '0);
        @(negedge clk);
        rst = 1'b1;
        we = 1'b0;
        for (int a = 1; a <= 6; a++) begin
            raddr1 = ADDR_W'(a);
            raddr2 = ADDR_W'(a);
            #1;
            checkOutput($sformatf("post_rst_r%0d_p1", a), rdata1, '0);
            checkOutput($sformatf("post_rst_r%0d_p2", a), rdata2, '0);
            @(negedge clk);
        end

        for (int i = 0; i < NREGS; i++) mdl[i] = '0;
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 39) != 0);
            if (!rst) begin
                for (int i = 0; i < NREGS; i++) mdl[i] = '0;
            end
            we     = $urandom_range(0, 1) == 1;
            waddr  = ADDR_W'($urandom_range(0, NREGS - 1));
            wdata  = DATA_W'($urandom);
            re1    = $urandom_range(0, 4) != 0;
            re2    = $urandom_range(0, 4) != 0;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : ADDR_W'($urandom_range(0, NREGS - 1));
            raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : ADDR_W'($urandom_range(0, NREGS - 1));
            #1;
            checkOutput($sformatf("rand%0d_rd1", n), rdata1, model_read(rst, re1, raddr1));
            checkOutput($sformatf("rand%0d_rd2", n), rdata2, model_read(rst, re2, raddr2));
            if (rst && we && waddr != 0) mdl[waddr] = wdata;
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
